// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply-divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle, sign-magnitude operands, HI/LO result registers.
//
// state | meaning
// IDLE  | waiting for start; HI/LO writable when not busy
// RUN   | WIDTH shift-add / restoring-divide steps
// FIX   | sign correction, result staged for commit on the following edge
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             is_div_q, is_div_d;
    logic             dbz_q, dbz_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             commit_q, commit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        signed_op = SIGNED_EN && !bus.op[0];
        a_neg     = signed_op && bus.a[WIDTH-1];
        b_neg     = signed_op && bus.b[WIDTH-1];
        a_mag     = a_neg ? (WIDTH'(0) - bus.a) : bus.a;
        b_mag     = b_neg ? (WIDTH'(0) - bus.b) : bus.b;

        mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mcand_q : WIDTH'(0))};
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        // When the subtract succeeds the true remainder is below the divisor, so the low bits suffice
        div_sub   = div_shift[WIDTH-1:0] - mcand_q;

        prod      = {acc_hi_q, acc_lo_q};
        prod_fix  = neg_q_q ? ((2*WIDTH)'(0) - prod) : prod;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        is_div_d = is_div_q;
        dbz_d    = dbz_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        commit_d = 1'b0;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = (state_q != IDLE) && !bus.cancel;

        if (!busy_q) begin
            if (bus.wr_hi) hi_d = bus.wr_data;
            if (bus.wr_lo) lo_d = bus.wr_data;
        end

        // Result lands one edge after FIX; a cancel in that window still kills it
        if (commit_q && !bus.cancel) begin
            hi_d   = res_hi_q;
            lo_d   = res_lo_q;
            done_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel && !busy_q) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = bus.op[1];
                    dbz_d    = bus.op[1] && (bus.b == '0);
                    neg_q_d  = a_neg ^ b_neg;
                    neg_r_d  = a_neg;
                    mcand_d  = bus.op[1] ? b_mag : a_mag;
                    acc_hi_d = '0;
                    acc_lo_d = bus.op[1] ? a_mag : b_mag;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.cancel) begin
                    commit_d = 1'b1;
                    if (is_div_q) begin
                        res_lo_d = dbz_q ? '1 : (neg_q_q ? (WIDTH'(0) - acc_lo_q) : acc_lo_q);
                        res_hi_d = neg_r_q ? (WIDTH'(0) - acc_hi_q) : acc_hi_q;
                    end else begin
                        res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        res_lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            is_div_q <= is_div_d;
            dbz_q    <= dbz_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            commit_q <= commit_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: latency, results, cancel, HI/LO writes, reset.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.cancel = 1'b0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    endtask

    // Full operation: noise on start/operands while busy, a blocked HI/LO write mid-run
    task automatic run_op(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit wr_at_start);
        int busy_bad;
        int done_bad;
        busy_bad = 0;
        done_bad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op_i; bus.a = a_i; bus.b = b_i;
        if (wr_at_start) begin
            bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h1111_1111;
        end
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        bus.op = ~op_i; bus.a = ~a_i; bus.b = b_i + 32'd1;
        if (wr_at_start) begin
            cur_hi = 32'h1111_1111; cur_lo = 32'h1111_1111;
            chk({tag, "/wr_with_start_hi"}, bus.hi, cur_hi);
            chk({tag, "/wr_with_start_lo"}, bus.lo, cur_lo);
        end
        chk({tag, "/busy_after_accept"}, {31'd0, bus.busy}, 32'd0);
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done !== 1'b0) done_bad++;
            if (n == 5) begin
                bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
            end
            if (n == 6) begin
                bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
                chk({tag, "/wr_hi_while_busy"}, bus.hi, cur_hi);
            end
        end
        chk({tag, "/busy_window"}, busy_bad, 0);
        chk({tag, "/no_early_done"}, done_bad, 0);
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "/done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "/busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "/hi"}, bus.hi, exp_hi);
        chk({tag, "/lo"}, bus.lo, exp_lo);
        cur_hi = exp_hi; cur_lo = exp_lo;
        @(negedge clk);
        chk({tag, "/done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "/no_requeue"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int bad;
        idle_inputs();
        bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.wr_data = 32'hFFFF_FFFF;
        bus.start = 1'b1; bus.wr_hi = 1'b1; bus.cancel = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset/hi", bus.hi, 32'h0);
        chk("reset/lo", bus.lo, 32'h0);
        chk("reset/busy", {31'd0, bus.busy}, 32'd0);
        chk("reset/done", {31'd0, bus.done}, 32'd0);
        idle_inputs();
        rst = 1'b1;

        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'h5A5A_5A5A;
        chk("mthi", bus.hi, 32'hA5A5_A5A5);
        @(negedge clk);
        bus.wr_lo = 1'b0;
        chk("mtlo", bus.lo, 32'h5A5A_5A5A);
        cur_hi = 32'hA5A5_A5A5; cur_lo = 32'h5A5A_5A5A;

        // multu cancelled at cycle 10, with a start riding along with the cancel
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 9; n++) @(negedge clk);
        bus.cancel = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        chk("cancel/busy", {31'd0, bus.busy}, 32'd0);
        chk("cancel/done", {31'd0, bus.done}, 32'd0);
        idle_inputs();
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("cancel/quiet", bad, 0);
        chk("cancel/hi", bus.hi, 32'hA5A5_A5A5);
        chk("cancel/lo", bus.lo, 32'h5A5A_5A5A);

        run_op("mult_m7x6",    2'b00, 32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        run_op("multu_max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        run_op("mult_pos",     2'b00, 32'h1234_5678, 32'h10,       32'h0000_0001, 32'h2345_6780, 1'b0);
        run_op("mult_m1xm1",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op("div_m7d2",     2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7dm2",     2'b10, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min_m1",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_by0",     2'b11, 32'h1234,     32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
        run_op("div_m5_by0",   2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_100d7",   2'b11, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E, 1'b0);

        // reset lands on edge 20 of a divide, together with start and a HI write
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 19; n++) @(negedge clk);
        rst = 1'b0; bus.start = 1'b1; bus.wr_hi = 1'b1; bus.wr_data = 32'h7777_7777;
        @(negedge clk);
        chk("rst_mid/hi", bus.hi, 32'h0);
        chk("rst_mid/lo", bus.lo, 32'h0);
        chk("rst_mid/busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid/done", {31'd0, bus.done}, 32'd0);
        idle_inputs();
        rst = 1'b1;
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("rst_mid/quiet", bad, 0);
        chk("rst_mid/hi_after", bus.hi, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
